// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider.
// Divisor changes are queued and applied only on a period boundary.
module clk_div_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             div_err,
    output logic [WIDTH-1:0] div_cur,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             fall_pulse
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_CNT = WIDTH'(DEFAULT_DIV - 1);
    localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

    logic [0:0]       st;
    logic [0:0]       st_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] pend_val;
    logic             pend_vld;
    logic [WIDTH-1:0] div_nxt;
    logic [WIDTH:0]   h_nxt;
    logic             boundary;
    logic             accept;
    logic             legal;

    assign pend_vld  = (st == ST_PEND);
    assign div_ready = !pend_vld;
    assign boundary  = (cnt == div_cur - ONE);
    assign accept    = div_valid & div_ready;
    assign legal     = (div_in >= TWO);

    // Next counter position, divisor for the coming cycle and its high length
    always_comb begin
        cnt_nxt = cnt + ONE;
        div_nxt = div_cur;
        if (boundary) begin
            cnt_nxt = '0;
            if (pend_vld) begin
                div_nxt = pend_val;
            end
        end
        // One extra bit so that N = 2^WIDTH-1 rounds up without wrapping
        h_nxt = ({1'b0, div_nxt} + ONE_X) >> 1;
    end

    // Control FSM: RUN until a legal request is queued, PEND until the boundary
    always_comb begin
        st_nxt = st;
        unique case (1'b1)
            (st == ST_RUN): begin
                if (accept && legal) begin
                    st_nxt = ST_PEND;
                end
            end
            (st == ST_PEND): begin
                if (boundary) begin
                    st_nxt = ST_RUN;
                end
            end
            default: st_nxt = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            st <= ST_RUN;
        end else begin
            st <= st_nxt;
        end
    end

    // Pending divisor captured on a legal accept
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            pend_val <= DEF_DIV;
        end else if (accept && legal) begin
            pend_val <= div_in;
        end
    end

    // Illegal request flag, one cycle after the accept
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            div_err <= 1'b0;
        end else begin
            div_err <= accept && !legal;
        end
    end

    // Period counter and divisor in effect
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            cnt     <= DEF_CNT;
            div_cur <= DEF_DIV;
        end else begin
            cnt     <= cnt_nxt;
            div_cur <= div_nxt;
        end
    end

    // Registered divided clock and its edge strobes
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            clk_out    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            clk_out    <= ({1'b0, cnt_nxt} < h_nxt);
            rise_pulse <= (cnt_nxt == '0);
            fall_pulse <= ({1'b0, cnt_nxt} == h_nxt);
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed vector table plus corner-case sequences
// for the programmable clock divider.
module tb_clk_div_prog;

    typedef struct {
        logic       vld;
        logic [7:0] din;
        logic       clk_o;
        logic       rise;
        logic       fall;
        logic       rdy;
        logic       err;
        logic [7:0] cur;
    } vec_t;

    logic       clk_in;
    logic       arst_n;
    logic [7:0] div_in;
    logic       div_valid;
    logic       div_ready;
    logic       div_err;
    logic [7:0] div_cur;
    logic       clk_out;
    logic       rise_pulse;
    logic       fall_pulse;

    int n_chk;
    int n_fail;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .clk_in    (clk_in),
        .arst_n    (arst_n),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_err   (div_err),
        .div_cur   (div_cur),
        .clk_out   (clk_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic vec_t v(input logic vl, input logic [7:0] d,
                               input logic c, input logic r, input logic f,
                               input logic rd, input logic e,
                               input logic [7:0] cu);
        vec_t t;
        t.vld = vl; t.din = d; t.clk_o = c; t.rise = r;
        t.fall = f; t.rdy = rd; t.err = e; t.cur = cu;
        return t;
    endfunction

    vec_t tbl[30];
    int   hi;
    int   guard;

    initial begin
        n_chk = 0;
        n_fail = 0;
        arst_n = 1'b0;
        div_valid = 1'b0;
        div_in = '0;

        for (int k = 0; k < 16; k++) begin
            tbl[k] = v(0, 0, (k % 4) < 2, (k % 4) == 0, (k % 4) == 2, 1, 0, 4);
        end
        tbl[16] = v(1, 1, 1, 1, 0, 1, 1, 4);
        tbl[17] = v(0, 0, 1, 0, 0, 1, 0, 4);
        tbl[18] = v(1, 0, 0, 0, 1, 1, 1, 4);
        tbl[19] = v(0, 0, 0, 0, 0, 1, 0, 4);
        tbl[20] = v(0, 0, 1, 1, 0, 1, 0, 4);
        tbl[21] = v(0, 0, 1, 0, 0, 1, 0, 4);
        tbl[22] = v(1, 5, 0, 0, 1, 0, 0, 4);
        tbl[23] = v(0, 0, 0, 0, 0, 0, 0, 4);
        tbl[24] = v(0, 0, 1, 1, 0, 1, 0, 5);
        tbl[25] = v(0, 0, 1, 0, 0, 1, 0, 5);
        tbl[26] = v(0, 0, 1, 0, 0, 1, 0, 5);
        tbl[27] = v(0, 0, 0, 0, 1, 1, 0, 5);
        tbl[28] = v(0, 0, 0, 0, 0, 1, 0, 5);
        tbl[29] = v(0, 0, 1, 1, 0, 1, 0, 5);

        step();
        step();
        chk("rst_clk", clk_out, 0);
        chk("rst_rise", rise_pulse, 0);
        chk("rst_fall", fall_pulse, 0);
        chk("rst_err", div_err, 0);
        chk("rst_rdy", div_ready, 1);
        chk("rst_cur", div_cur, 4);
        #2 arst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            div_valid = tbl[i].vld;
            div_in = tbl[i].din;
            step();
            chk($sformatf("v%0d_clk", i + 1), clk_out, tbl[i].clk_o);
            chk($sformatf("v%0d_rise", i + 1), rise_pulse, tbl[i].rise);
            chk($sformatf("v%0d_fall", i + 1), fall_pulse, tbl[i].fall);
            chk($sformatf("v%0d_rdy", i + 1), div_ready, tbl[i].rdy);
            chk($sformatf("v%0d_err", i + 1), div_err, tbl[i].err);
            chk($sformatf("v%0d_cur", i + 1), div_cur, tbl[i].cur);
        end
        div_valid = 1'b0;

        // Back-to-back: 2 then 255 with div_valid held
        div_valid = 1'b1;
        div_in = 8'd2;
        step();
        chk("b2b_rdy0", div_ready, 0);
        div_in = 8'd255;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b_wait_cur", div_cur, 5);
            chk("b2b_wait_rdy", div_ready, 0);
        end
        step();
        chk("b2b_sw2_cur", div_cur, 2);
        chk("b2b_sw2_rise", rise_pulse, 1);
        chk("b2b_sw2_rdy", div_ready, 1);
        step();
        chk("b2b_acc_rdy", div_ready, 0);
        chk("b2b_acc_clk", clk_out, 0);
        chk("b2b_acc_fall", fall_pulse, 1);
        chk("b2b_acc_cur", div_cur, 2);
        div_valid = 1'b0;
        step();
        chk("b2b_sw255_cur", div_cur, 255);
        chk("b2b_sw255_rise", rise_pulse, 1);
        chk("b2b_sw255_rdy", div_ready, 1);

        // 255-cycle period: 128 high, 127 low
        hi = 0;
        for (int i = 0; i < 255; i++) begin
            if (i > 0) step();
            hi += int'(clk_out);
            if (i == 128) chk("p255_fall", fall_pulse, 1);
        end
        chk("p255_high", hi, 128);
        step();
        chk("p255_next_rise", rise_pulse, 1);

        // Return to 4; wait is bounded
        div_valid = 1'b1;
        div_in = 8'd4;
        step();
        div_valid = 1'b0;
        guard = 0;
        while (div_cur != 8'd4 && guard < 300) begin
            step();
            guard++;
        end
        chk("to4_timeout", int'(guard < 300), 1);
        chk("to4_rise", rise_pulse, 1);

        // Request on the boundary edge applies one full period later
        step();
        step();
        step();
        div_valid = 1'b1;
        div_in = 8'd3;
        step();
        div_valid = 1'b0;
        chk("bnd_cur", div_cur, 4);
        chk("bnd_rise", rise_pulse, 1);
        chk("bnd_rdy", div_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bnd_hold_cur", div_cur, 4);
        end
        step();
        chk("bnd_sw_cur", div_cur, 3);
        chk("bnd_sw_rise", rise_pulse, 1);
        chk("bnd_sw_rdy", div_ready, 1);

        // Async reset during high phase with a request pending
        div_valid = 1'b1;
        div_in = 8'd6;
        step();
        div_valid = 1'b0;
        chk("ar_pre_clk", clk_out, 1);
        chk("ar_pre_rdy", div_ready, 0);
        #2 arst_n = 1'b0;
        #1;
        chk("ar_clk", clk_out, 0);
        chk("ar_rdy", div_ready, 1);
        chk("ar_cur", div_cur, 4);
        #2 arst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("ar_post_clk", clk_out, int'((k % 4) < 2));
            chk("ar_post_rise", rise_pulse, int'((k % 4) == 0));
            chk("ar_post_fall", fall_pulse, int'((k % 4) == 2));
            chk("ar_post_cur", div_cur, 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider with a glitch-free divisor-change handshake. It generates `clk_out` at `clk_in`/N for any N in [2, 2^WIDTH-1], odd or even, plus single-cycle rise/fall strobes in the `clk_in` domain. It sits beside the fixed even-only divider in the clock tree, where software or a control FSM must retune a divided clock without a reset. Divisor changes take effect only on a period boundary, so no runt pulses appear.

## Interface
- `WIDTH`, 8: width of the divisor and of the internal counter. Legal range is WIDTH >= 2.
- `DEFAULT_DIV`, 4: divisor loaded at reset. Legal range is [2, 2^WIDTH-1].
- `clk_in` input 1: the single clock. All logic is on its rising edge.
- `arst_n` input 1: reset, asynchronous and active-low.
- `div_in` input WIDTH: requested divisor. Sampled when `div_valid & div_ready`.
- `div_valid` input 1: request strobe. The requester holds `div_valid` and `div_in` stable until accepted.
- `div_ready` output 1: high when no accepted request is pending.
- `div_err` output 1: one-cycle pulse. Indicates that an accepted request had `div_in` < 2.
- `div_cur` output WIDTH: divisor currently in effect.
- `clk_out` output 1: divided clock, registered.
- `rise_pulse` output 1: high for exactly the `clk_in` cycle in which `clk_out` is in its first high cycle.
- `fall_pulse` output 1: high for exactly the `clk_in` cycle in which `clk_out` is in its first low cycle.

## Operation
- **State:**
  - `cnt` (WIDTH bits) holds the position within the period, 0..N-1.
  - `div_cur` holds N.
  - `pend_val` (WIDTH bits) and `pend_vld` (1 bit) hold an accepted request.
- **Period:** N `clk_in` cycles.
  - High length H = ceil(N/2) = (N+1)>>1. Compute this at WIDTH+1 bits so N = 2^WIDTH-1 does not overflow.
  - `clk_out` is high while `cnt` < H and low otherwise. Odd N gives a high phase one cycle longer than the low phase.
- **Counter:** `cnt_nxt` = 0 if `cnt` == `div_cur`-1, else `cnt`+1. The registers take:
  - `clk_out` <= (`cnt_nxt` < H_next)
  - `rise_pulse` <= (`cnt_nxt` == 0)
  - `fall_pulse` <= (`cnt_nxt` == H_next)
- **Boundary:** the edge where `cnt` == `div_cur`-1.
  - If `pend_vld` is set: `div_cur` <= `pend_val` and `pend_vld` <= 0.
  - H_next is computed from the divisor in effect for the new period.
- **Handshake:**
  - `div_ready` = !`pend_vld` (combinational from state).
  - On `div_valid & div_ready` with `div_in` >= 2: `pend_val` <= `div_in` and `pend_vld` <= 1.
  - On `div_valid & div_ready` with `div_in` < 2: the request is consumed, `pend_vld` stays 0, and `div_err` pulses on the next cycle. `div_cur` is unchanged.
- **Request on a boundary edge with no request pending:** the request is accepted into the pending register. It applies at the following boundary, not the current one.
- **Boundary with a new `div_valid` in the same cycle:** `div_ready` is low that cycle, so there is no accept. The request is accepted on the next cycle.
- **Two-state control FSM:**
  - RUN (`pend_vld`=0) goes to PEND on a legal accept.
  - PEND goes to RUN at a boundary.
  - No other transitions.

## Timing
- **Reset values:**
  - `clk_out`=0, `rise_pulse`=0, `fall_pulse`=0, `div_err`=0, `div_ready`=1.
  - `div_cur`=DEFAULT_DIV, `cnt`=DEFAULT_DIV-1, `pend_vld`=0.
- **First edge after reset release:** `cnt`=0, `clk_out`=1, `rise_pulse`=1. The output starts with a full high phase.
- **Output timing:** all outputs change only on `clk_in` rising edges, except asynchronously on reset. `clk_out` is glitch-free and has no runt phase across a divisor change.
- **Accept-to-effect latency:** from the accept edge to the first cycle of the new period is between 1 and `div_cur` cycles.
  - `div_ready` returns high in the cycle after the switching edge.
- **Reset mid-operation:** all state returns to its reset value immediately. Any pending request is dropped and any in-flight `div_err` is cancelled.

## Test plan
- **Reset, then 16 cycles at DEFAULT_DIV=4:**
  - `clk_out` = 1,1,0,0 repeating.
  - `rise_pulse` on cycles 1, 5, 9, 13.
  - `fall_pulse` on cycles 3, 7, 11, 15.
- **Request `div_in`=5 accepted at `cnt`=1:**
  - The current period finishes as 4 cycles.
  - Next period is 1,1,1,0,0 and `div_cur` reads 5 from its first cycle.
  - `div_ready` is low from the accept until that switch.
- **Request `div_in`=1, then `div_in`=0:**
  - Each is accepted immediately.
  - `div_err` pulses for 1 cycle each time.
  - `div_cur` stays 4 and the waveform is unaffected.
- **Back-to-back requests 2 then 255, with `div_valid` held:**
  - Second request stalls until the cycle after the switch to 2.
  - It then applies after exactly one 2-cycle period.
  - 255-period: 128 high and 127 low, with no overflow in H.
- **Request coinciding with a boundary edge (`cnt`=3, N=4):** the new divisor takes effect one full 4-cycle period later, not at this boundary.
- **`arst_n` pulsed low during a high phase with a request pending:**
  - `clk_out` drops to 0 asynchronously.
  - After release, the output is again the DEFAULT_DIV pattern and `div_ready`=1.
